// File: rtl/arbitro_vc_fc_pkg.sv
// rtl/arbitro_vc_fc_pkg.sv - shared state encodings and default widths for the VC flow-control arbiter
package arbitro_vc_fc_pkg;

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_INIT   = 2'd1,
        ST_IDLE   = 2'd2,
        ST_ACTIVE = 2'd3
    } state_t;

    localparam int BITNUMBER_DEF = 6;
    localparam int DEST_BIT_DEF  = 4;
    localparam int FILL_W_DEF    = 4;
    localparam int CNT_W_DEF     = 8;

endpackage

// File: rtl/arbitro_vc_sel.sv
// rtl/arbitro_vc_sel.sv - combinational VC0-priority select with destination almost-full blocking
//
// Ports:
//   active                 arbitration enabled (FSM in ACTIVE)
//   vc0_empty, vc1_empty   VC FIFO empty flags
//   vc0_data, vc1_data     VC head words
//   d0_fill, d1_fill       destination occupancy
//   d0_inflight, d1_inflight  registered push already headed to each destination
//   umbral_d               destination almost-full threshold
//   pop_vc0, pop_vc1       at most one asserted per cycle
//   sel_data, sel_dest     word and destination of the granted VC
module arbitro_vc_sel
    import arbitro_vc_fc_pkg::*;
#(
    parameter int BITNUMBER = BITNUMBER_DEF,
    parameter int DEST_BIT  = DEST_BIT_DEF,
    parameter int FILL_W    = FILL_W_DEF
) (
    input  logic                 active,
    input  logic                 vc0_empty,
    input  logic                 vc1_empty,
    input  logic [BITNUMBER-1:0] vc0_data,
    input  logic [BITNUMBER-1:0] vc1_data,
    input  logic [FILL_W-1:0]    d0_fill,
    input  logic [FILL_W-1:0]    d1_fill,
    input  logic                 d0_inflight,
    input  logic                 d1_inflight,
    input  logic [FILL_W-1:0]    umbral_d,
    output logic                 pop_vc0,
    output logic                 pop_vc1,
    output logic [BITNUMBER-1:0] sel_data,
    output logic                 sel_dest
);

    // One extra bit so fill + in-flight word cannot overflow before the compare.
    logic [FILL_W:0] occ_d0;
    logic [FILL_W:0] occ_d1;
    logic            blocked_d0;
    logic            blocked_d1;
    logic            dest0;
    logic            dest1;
    logic            blocked_vc0;
    logic            blocked_vc1;

    always_comb begin
        occ_d0      = {1'b0, d0_fill} + {{FILL_W{1'b0}}, d0_inflight};
        occ_d1      = {1'b0, d1_fill} + {{FILL_W{1'b0}}, d1_inflight};
        blocked_d0  = occ_d0 >= {1'b0, umbral_d};
        blocked_d1  = occ_d1 >= {1'b0, umbral_d};
        dest0       = vc0_data[DEST_BIT];
        dest1       = vc1_data[DEST_BIT];
        blocked_vc0 = dest0 ? blocked_d1 : blocked_d0;
        blocked_vc1 = dest1 ? blocked_d1 : blocked_d0;

        // VC0 wins whenever it can move; a stuck VC0 head leaves VC1 free to go.
        pop_vc0  = active && !vc0_empty && !blocked_vc0;
        pop_vc1  = active && !vc1_empty && !blocked_vc1 && !pop_vc0;
        sel_data = pop_vc1 ? vc1_data : vc0_data;
        sel_dest = pop_vc1 ? dest1 : dest0;
    end

endmodule

// File: rtl/arbitro_vc_fc.sv
// rtl/arbitro_vc_fc.sv - flow-control FSM and arbiter draining VC0/VC1 into D0/D1
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   init                        threshold load request (forces INIT)
//   Umbral_VC_in, Umbral_D_in   thresholds captured while in INIT
//   VC0_/VC1_empty,_fill,_data  VC FIFO status and head word
//   D0_fill, D1_fill            destination occupancy
//   pop_VC0, pop_VC1            combinational pops
//   push_D0, push_D1, data_out  registered write to the destinations
//   VC_pause                    registered upstream pause
//   state                       FSM state (RESET/INIT/IDLE/ACTIVE)
//   cnt_D0, cnt_D1              wrapping transfer counters
module arbitro_vc_fc
    import arbitro_vc_fc_pkg::*;
#(
    parameter int BITNUMBER = BITNUMBER_DEF,
    parameter int DEST_BIT  = DEST_BIT_DEF,
    parameter int FILL_W    = FILL_W_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 init,
    input  logic [FILL_W-1:0]    Umbral_VC_in,
    input  logic [FILL_W-1:0]    Umbral_D_in,
    input  logic                 VC0_empty,
    input  logic                 VC1_empty,
    input  logic [FILL_W-1:0]    VC0_fill,
    input  logic [FILL_W-1:0]    VC1_fill,
    input  logic [BITNUMBER-1:0] VC0_data,
    input  logic [BITNUMBER-1:0] VC1_data,
    input  logic [FILL_W-1:0]    D0_fill,
    input  logic [FILL_W-1:0]    D1_fill,
    output logic                 pop_VC0,
    output logic                 pop_VC1,
    output logic                 push_D0,
    output logic                 push_D1,
    output logic [BITNUMBER-1:0] data_out,
    output logic                 VC_pause,
    output logic [1:0]           state,
    output logic [CNT_W-1:0]     cnt_D0,
    output logic [CNT_W-1:0]     cnt_D1
);

    state_t                st;
    logic [FILL_W-1:0]     umbral_vc;
    logic [FILL_W-1:0]     umbral_d;
    logic [BITNUMBER-1:0]  sel_data;
    logic                  sel_dest;
    logic                  pop_any;

    assign state   = st;
    assign pop_any = pop_VC0 || pop_VC1;

    arbitro_vc_sel #(
        .BITNUMBER (BITNUMBER),
        .DEST_BIT  (DEST_BIT),
        .FILL_W    (FILL_W)
    ) u_sel (
        .active      (st == ST_ACTIVE),
        .vc0_empty   (VC0_empty),
        .vc1_empty   (VC1_empty),
        .vc0_data    (VC0_data),
        .vc1_data    (VC1_data),
        .d0_fill     (D0_fill),
        .d1_fill     (D1_fill),
        .d0_inflight (push_D0),
        .d1_inflight (push_D1),
        .umbral_d    (umbral_d),
        .pop_vc0     (pop_VC0),
        .pop_vc1     (pop_VC1),
        .sel_data    (sel_data),
        .sel_dest    (sel_dest)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            st        <= ST_RESET;
            push_D0   <= 1'b0;
            push_D1   <= 1'b0;
            data_out  <= '0;
            VC_pause  <= 1'b0;
            cnt_D0    <= '0;
            cnt_D1    <= '0;
            umbral_vc <= '0;
            umbral_d  <= '0;
        end else begin
            // A pop granted this cycle always lands next cycle, even if init
            // pulls the FSM back to INIT.
            push_D0 <= pop_any && !sel_dest;
            push_D1 <= pop_any && sel_dest;
            if (pop_any) begin
                data_out <= sel_data;
            end

            if (push_D0) begin
                cnt_D0 <= cnt_D0 + CNT_W'(1);
            end
            if (push_D1) begin
                cnt_D1 <= cnt_D1 + CNT_W'(1);
            end

            VC_pause <= (st != ST_RESET) &&
                        ((VC0_fill >= umbral_vc) || (VC1_fill >= umbral_vc));

            if (st == ST_INIT) begin
                umbral_vc <= Umbral_VC_in;
                umbral_d  <= Umbral_D_in;
            end

            if (init) begin
                st <= ST_INIT;
            end else begin
                case (st)
                    ST_RESET:  st <= ST_INIT;
                    ST_INIT:   st <= ST_IDLE;
                    ST_IDLE:   if (!VC0_empty || !VC1_empty) st <= ST_ACTIVE;
                    ST_ACTIVE: if (VC0_empty && VC1_empty && !pop_any) st <= ST_IDLE;
                    default:   st <= ST_RESET;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_arbitro_vc_fc.sv
// tb/tb_arbitro_vc_fc.sv - self-checking bench for arbitro_vc_fc
module tb_arbitro_vc_fc;

    localparam int BN = 6;
    localparam int FW = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          init;
    logic [FW-1:0] Umbral_VC_in;
    logic [FW-1:0] Umbral_D_in;
    logic          VC0_empty, VC1_empty;
    logic [FW-1:0] VC0_fill, VC1_fill;
    logic [BN-1:0] VC0_data, VC1_data;
    logic [FW-1:0] D0_fill, D1_fill;
    logic          pop_VC0, pop_VC1, push_D0, push_D1, VC_pause;
    logic [BN-1:0] data_out;
    logic [1:0]    state;
    logic [CW-1:0] cnt_D0, cnt_D1;

    int total = 0;
    int bad   = 0;
    int exp_cnt0 = 0;
    int exp_cnt1 = 0;

    logic [BN-1:0] vc0_q[$];
    logic [BN-1:0] vc1_q[$];
    logic [BN-1:0] sb_q[$];
    logic [BN-1:0] sb_w;

    always #5 clk = ~clk;

    arbitro_vc_fc dut (
        .clk          (clk),
        .reset        (reset),
        .init         (init),
        .Umbral_VC_in (Umbral_VC_in),
        .Umbral_D_in  (Umbral_D_in),
        .VC0_empty    (VC0_empty),
        .VC1_empty    (VC1_empty),
        .VC0_fill     (VC0_fill),
        .VC1_fill     (VC1_fill),
        .VC0_data     (VC0_data),
        .VC1_data     (VC1_data),
        .D0_fill      (D0_fill),
        .D1_fill      (D1_fill),
        .pop_VC0      (pop_VC0),
        .pop_VC1      (pop_VC1),
        .push_D0      (push_D0),
        .push_D1      (push_D1),
        .data_out     (data_out),
        .VC_pause     (VC_pause),
        .state        (state),
        .cnt_D0       (cnt_D0),
        .cnt_D1       (cnt_D1)
    );

    // Scoreboard: every push must match the oldest word the bench expected to be popped.
    always @(negedge clk) begin
        if (push_D0 || push_D1) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected_push push_D0=%b push_D1=%b data_out=%b required no push",
                         push_D0, push_D1, data_out);
            end else begin
                sb_w = sb_q.pop_front();
                if (data_out !== sb_w || push_D0 !== !sb_w[4] || push_D1 !== sb_w[4]) begin
                    bad++;
                    $display("FAIL sb_push data_out=%b push_D0=%b push_D1=%b required data=%b push_D0=%b push_D1=%b",
                             data_out, push_D0, push_D1, sb_w, !sb_w[4], sb_w[4]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_vcs();
        VC0_empty = (vc0_q.size() == 0);
        VC1_empty = (vc1_q.size() == 0);
        VC0_data  = VC0_empty ? '0 : vc0_q[0];
        VC1_data  = VC1_empty ? '0 : vc1_q[0];
    endtask

    task automatic consume(input logic p0, input logic p1);
        logic [BN-1:0] w;
        if (p0 && vc0_q.size() > 0) begin
            w = vc0_q.pop_front();
            sb_q.push_back(w);
            if (w[4]) exp_cnt1++; else exp_cnt0++;
        end
        if (p1 && vc1_q.size() > 0) begin
            w = vc1_q.pop_front();
            sb_q.push_back(w);
            if (w[4]) exp_cnt1++; else exp_cnt0++;
        end
    endtask

    task automatic do_init(input logic [FW-1:0] thr_vc, input logic [FW-1:0] thr_d);
        init = 1'b1;
        Umbral_VC_in = thr_vc;
        Umbral_D_in  = thr_d;
        tick();
        init = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; init = 1'b0;
        Umbral_VC_in = '0; Umbral_D_in = '0;
        VC0_fill = '0; VC1_fill = '0; D0_fill = '0; D1_fill = '0;
        drive_vcs();
        tick();
        tick();
        total++;
        if (state !== 2'd0) begin
            bad++; $display("FAIL reset_state state=%0d required 0", state);
        end
        total++;
        if ({pop_VC0, pop_VC1, push_D0, push_D1, VC_pause} !== 5'b0) begin
            bad++; $display("FAIL reset_flags pops/pushes/pause=%b required 00000",
                            {pop_VC0, pop_VC1, push_D0, push_D1, VC_pause});
        end
        total++;
        if (data_out !== '0 || cnt_D0 !== '0 || cnt_D1 !== '0) begin
            bad++; $display("FAIL reset_data data_out=%b cnt_D0=%0d cnt_D1=%0d required 0 0 0",
                            data_out, cnt_D0, cnt_D1);
        end
        reset = 1'b0; init = 1'b1; Umbral_VC_in = 4'd1; Umbral_D_in = 4'd1;
        tick();
        total++;
        if (state !== 2'd1) begin
            bad++; $display("FAIL reset_to_init state=%0d required 1", state);
        end
        init = 1'b0;
        tick();
        total++;
        if (state !== 2'd2) begin
            bad++; $display("FAIL init_to_idle state=%0d required 2", state);
        end
        tick();
        total++;
        if (VC_pause !== 1'b0 || state !== 2'd2) begin
            bad++; $display("FAIL idle_settle VC_pause=%b state=%0d required 0 2", VC_pause, state);
        end
    endtask

    task automatic test_single();
        logic [2:0] e0 = 3'b010;
        do_init(4'd8, 4'd3);
        vc0_q.push_back(6'b000001);
        for (int c = 0; c < 3; c++) begin
            drive_vcs();
            @(negedge clk);
            total++;
            if (pop_VC0 !== e0[c] || pop_VC1 !== 1'b0) begin
                bad++; $display("FAIL single_pop cyc=%0d pop_VC0=%b pop_VC1=%b required %b 0",
                                c, pop_VC0, pop_VC1, e0[c]);
            end
            consume(e0[c], 1'b0);
            tick();
        end
        total++;
        if (cnt_D0 !== CW'(exp_cnt0)) begin
            bad++; $display("FAIL single_cnt cnt_D0=%0d required %0d", cnt_D0, exp_cnt0);
        end
    endtask

    task automatic test_no_hol();
        logic [4:0] e0 = 5'b01000;
        logic [4:0] e1 = 5'b00010;
        do_init(4'd8, 4'd3);
        D0_fill = 4'd0; D1_fill = 4'd3;
        vc0_q.push_back(6'b010000);
        vc1_q.push_back(6'b000010);
        for (int c = 0; c < 5; c++) begin
            if (c == 3) D1_fill = 4'd0;
            drive_vcs();
            @(negedge clk);
            total++;
            if (pop_VC0 !== e0[c] || pop_VC1 !== e1[c]) begin
                bad++; $display("FAIL no_hol_pop cyc=%0d pop_VC0=%b pop_VC1=%b required %b %b",
                                c, pop_VC0, pop_VC1, e0[c], e1[c]);
            end
            consume(e0[c], e1[c]);
            tick();
        end
        total++;
        if (cnt_D0 !== CW'(exp_cnt0) || cnt_D1 !== CW'(exp_cnt1)) begin
            bad++; $display("FAIL no_hol_cnt cnt_D0=%0d cnt_D1=%0d required %0d %0d",
                            cnt_D0, cnt_D1, exp_cnt0, exp_cnt1);
        end
    endtask

    task automatic test_throttle();
        logic [9:0] e0 = 10'b0000001010;
        logic [9:0] e1 = 10'b0010100000;
        do_init(4'd8, 4'd2);
        D0_fill = 4'd1; D1_fill = 4'd0;
        vc0_q.push_back(6'b000011);
        vc0_q.push_back(6'b100101);
        vc1_q.push_back(6'b000110);
        vc1_q.push_back(6'b001000);
        for (int c = 0; c < 10; c++) begin
            drive_vcs();
            @(negedge clk);
            total++;
            if (pop_VC0 !== e0[c] || pop_VC1 !== e1[c]) begin
                bad++; $display("FAIL throttle_pop cyc=%0d pop_VC0=%b pop_VC1=%b required %b %b",
                                c, pop_VC0, pop_VC1, e0[c], e1[c]);
            end
            consume(e0[c], e1[c]);
            tick();
        end
        D0_fill = 4'd0;
        total++;
        if (cnt_D0 !== CW'(exp_cnt0) || state !== 2'd2) begin
            bad++; $display("FAIL throttle_end cnt_D0=%0d state=%0d required %0d 2",
                            cnt_D0, state, exp_cnt0);
        end
    endtask

    task automatic test_pause();
        do_init(4'd4, 4'd8);
        VC0_fill = 4'd4;
        tick();
        total++;
        if (VC_pause !== 1'b1) begin
            bad++; $display("FAIL pause_vc0_on VC_pause=%b required 1", VC_pause);
        end
        VC0_fill = 4'd3;
        @(negedge clk);
        total++;
        if (VC_pause !== 1'b1) begin
            bad++; $display("FAIL pause_registered VC_pause=%b required 1", VC_pause);
        end
        tick();
        total++;
        if (VC_pause !== 1'b0) begin
            bad++; $display("FAIL pause_vc0_off VC_pause=%b required 0", VC_pause);
        end
        VC1_fill = 4'd5;
        tick();
        total++;
        if (VC_pause !== 1'b1) begin
            bad++; $display("FAIL pause_vc1_on VC_pause=%b required 1", VC_pause);
        end
        VC1_fill = 4'd0; VC0_fill = 4'd0;
        do_init(4'd0, 4'd8);
        tick();
        total++;
        if (VC_pause !== 1'b1) begin
            bad++; $display("FAIL pause_zero_thr VC_pause=%b required 1", VC_pause);
        end
        do_init(4'd8, 4'd8);
        tick();
    endtask

    task automatic test_reset_mid();
        do_init(4'd8, 4'd8);
        vc0_q.push_back(6'b000111);
        drive_vcs();
        tick();
        drive_vcs();
        @(negedge clk);
        total++;
        if (pop_VC0 !== 1'b1) begin
            bad++; $display("FAIL rst_mid_pop pop_VC0=%b required 1", pop_VC0);
        end
        reset = 1'b1;
        vc0_q.delete();
        tick();
        drive_vcs();
        total++;
        if (push_D0 !== 1'b0 || push_D1 !== 1'b0 || state !== 2'd0) begin
            bad++; $display("FAIL rst_mid_push push_D0=%b push_D1=%b state=%0d required 0 0 0",
                            push_D0, push_D1, state);
        end
        total++;
        if (cnt_D0 !== '0 || cnt_D1 !== '0) begin
            bad++; $display("FAIL rst_mid_cnt cnt_D0=%0d cnt_D1=%0d required 0 0", cnt_D0, cnt_D1);
        end
        exp_cnt0 = 0; exp_cnt1 = 0;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_wrap();
        logic          p;
        logic [BN-1:0] w;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        exp_cnt0 = 0; exp_cnt1 = 0;
        do_init(4'd8, 4'd8);
        D0_fill = 4'd0; D1_fill = 4'd0;
        for (int i = 0; i < 256; i++) begin
            w = BN'(i % 16);
            w[5] = (i % 32) >= 16;
            vc0_q.push_back(w);
        end
        for (int c = 0; c < 260; c++) begin
            drive_vcs();
            @(negedge clk);
            p = (c >= 1 && c <= 256);
            total++;
            if (pop_VC0 !== p || pop_VC1 !== 1'b0) begin
                bad++; $display("FAIL wrap_pop cyc=%0d pop_VC0=%b pop_VC1=%b required %b 0",
                                c, pop_VC0, pop_VC1, p);
            end
            if (c == 257) begin
                total++;
                if (cnt_D0 !== 8'd255) begin
                    bad++; $display("FAIL wrap_cnt_max cnt_D0=%0d required 255", cnt_D0);
                end
            end
            if (c == 258) begin
                total++;
                if (cnt_D0 !== 8'd0 || cnt_D1 !== 8'd0) begin
                    bad++; $display("FAIL wrap_cnt_zero cnt_D0=%0d cnt_D1=%0d required 0 0", cnt_D0, cnt_D1);
                end
            end
            consume(p, 1'b0);
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_no_hol();
        test_throttle();
        test_pause();
        test_reset_mid();
        test_wrap();
        tick();
        total++;
        if (sb_q.size() != 0) begin
            bad++; $display("FAIL sb_leftover pending=%0d required 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/arbitro_vc_fc.md
Name: arbitro_vc_fc

Overview:
- Flow-control controller and arbiter between the two virtual-channel FIFOs (VC0, VC1) and the two destination FIFOs (D0, D1).
- Sequences the init/threshold phase and drains VC0/VC1 heads into D0/D1 according to the destination bit.
- Throttles on destination almost-full thresholds and raises the upstream pause when either VC FIFO reaches its threshold.
- Keeps per-destination transfer counters for the probador/scoreboard.

Parameters:
- BITNUMBER, 6, packet width; bit 5 = VC select (already consumed upstream), bit DEST_BIT = destination.
- DEST_BIT, 4, index of the destination-select bit (0 -> D0, 1 -> D1).
- FILL_W, 4, width of FIFO occupancy inputs and thresholds (FIFO depth 8 -> values 0..8).
- CNT_W, 8, width of the transfer counters.

Ports:
- clk  in  1  system clock, all logic on posedge
- reset  in  1  synchronous, active-high
- init  in  1  threshold load request
- Umbral_VC_in  in  FILL_W  VC almost-full threshold
- Umbral_D_in  in  FILL_W  D almost-full threshold
- VC0_empty, VC1_empty  in  1  VC FIFO empty flags
- VC0_fill, VC1_fill  in  FILL_W  VC occupancy
- VC0_data, VC1_data  in  BITNUMBER  VC head word (first-word fall-through)
- D0_fill, D1_fill  in  FILL_W  destination occupancy
- pop_VC0, pop_VC1  out  1  combinational pops
- push_D0, push_D1  out  1  registered pushes
- data_out  out  BITNUMBER  registered word to D0/D1
- VC_pause  out  1  registered upstream pause
- state  out  2  current FSM state
- cnt_D0, cnt_D1  out  CNT_W  accepted-transfer counters

Behaviour:
- Reset (reset=1 at posedge): state=RESET, all pops/pushes 0, data_out=0, VC_pause=0, cnt_D0=cnt_D1=0, internal thresholds=0. Reset mid-transfer discards any in-flight word; no push occurs on the following cycle.
- FSM states: RESET=0, INIT=1, IDLE=2, ACTIVE=3.
  - RESET -> INIT on the first cycle with reset=0.
  - INIT: load umbral_vc <= Umbral_VC_in and umbral_d <= Umbral_D_in every cycle. Go to IDLE when init=0.
  - Any state with init=1 -> INIT (reload). Pops are forced 0 in INIT and RESET.
  - IDLE -> ACTIVE when VC0_empty=0 or VC1_empty=0.
  - ACTIVE -> IDLE when both are empty and no pop is issued this cycle.
- Blocking rule: blocked_Dx = (D_fill_x + push_Dx) >= umbral_d. The registered push_Dx counts as an in-flight word. umbral_d=0 blocks everything.
- Arbitration (ACTIVE only), at most one pop per cycle:
  - VC0 has strict priority: pop_VC0 = !VC0_empty && !blocked(dest(VC0_data)).
  - Otherwise pop_VC1 = !VC1_empty && !blocked(dest(VC1_data)).
  - A blocked VC0 head does not block VC1 (no cross-VC head-of-line blocking).
- Datapath latency: 1 cycle. On the cycle after pop_VCx, data_out = popped word and push_D{dest}=1; the other push is 0. With no pop, both pushes are 0 and data_out holds its value.
- Counters: cnt_Dx increments on each cycle with push_Dx=1. Wraps 2^CNT_W-1 -> 0. Cleared only by reset; init does not clear them.
- VC_pause: registered (VC0_fill >= umbral_vc) || (VC1_fill >= umbral_vc), evaluated in every state except RESET. umbral_vc=0 gives VC_pause=1.
- Simultaneous events: init=1 while a push is pending still completes that push next cycle. reset has priority over init.

Decomposition:
- Shared package: state encodings RESET/INIT/IDLE/ACTIVE, DEST_BIT default, FILL_W/CNT_W defaults.
- One natural sub-module, arbitro_vc_sel: combinational priority select plus blocking check, producing pop_VC0/pop_VC1/sel_data/sel_dest.
- FSM, output registers and counters stay in the top.

Test Plan:
- Reset 2 cycles, then init=1 for 1 cycle with Umbral_D_in=1 and Umbral_VC_in=1 -> state goes RESET, INIT, then IDLE. All outputs 0 through reset.
- VC0 head 'b000001, D0_fill=0, Umbral_D=3 -> pop_VC0 in cycle n; push_D0=1 and data_out='b000001 in n+1; cnt_D0=1.
- VC0 head 'b010000 with D1_fill=3 and Umbral_D=3, VC1 head 'b000010 with D0_fill=0 -> pop_VC1 only; push_D0 next cycle with 'b000010.
- Both VCs non-empty, D0_fill=1, Umbral_D=2, continuous D0 traffic -> pop on one cycle, blocked the next (in-flight counted). D0 never exceeds 2.
- VC0_fill=4, Umbral_VC=4 -> VC_pause=1 one cycle later. Fill drops to 3 -> VC_pause=0 one cycle later.
- 256 D0 transfers -> cnt_D0 wraps to 0. Reset asserted with a pending pop -> no push the next cycle, counters 0.
